x3q16_alu: RTL and testbench

//  16-bit, 8-operation ALU for the x3q16 CPU datapath.
//  - Combinational datapath: result and compare flags follow a, b and mode with no clock.
//  - Registered shadow outputs (_q) give the pipeline/flag register a one-cycle-late copy.
//  - Compare flags depend only on a and b, never on mode, so branch logic reads them under any op.

---
 rtl/x3q16_alu.sv | 69 ++++++
 tb/tb_x3q16_alu.sv | 133 +++++++++++++
 2 files changed

// File: rtl/x3q16_alu.sv
// rtl/x3q16_alu.sv - 16-bit eight-operation ALU with compare flags and registered shadow outputs
// The shadow outputs give the flag register a one-cycle-late copy of the combinational path.

module x3q16_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       mode,
    output logic [WIDTH-1:0] result,
    output logic             equal_flag,
    output logic             greater_a_flag,
    output logic [WIDTH-1:0] result_q,
    output logic             equal_flag_q,
    output logic             greater_a_flag_q
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_NOT = 3'b111
    } op_t;

    op_t        op;
    logic [3:0] shamt;

    assign op    = op_t'(mode);
    // Only the low nibble of b is a shift count; the upper bits are don't-care.
    assign shamt = b[3:0];

    always_comb begin
        result = '0;
        unique case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL:  result = a << shamt;
            OP_SHR:  result = a >> shamt;
            OP_NOT:  result = ~a;
            default: result = '0;
        endcase
    end

    // Flags ignore mode so branch logic can read them under any operation.
    assign equal_flag     = (a == b);
    assign greater_a_flag = (a > b);

    always_ff @(posedge clk) begin
        if (!reset) begin
            result_q         <= '0;
            equal_flag_q     <= 1'b0;
            greater_a_flag_q <= 1'b0;
        end else begin
            result_q         <= result;
            equal_flag_q     <= equal_flag;
            greater_a_flag_q <= greater_a_flag;
        end
    end

endmodule

// File: tb/tb_x3q16_alu.sv
// tb/tb_x3q16_alu.sv - directed self-checking bench for x3q16_alu

module tb_x3q16_alu;

    logic        clk;
    logic        reset;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  mode;
    logic [15:0] result;
    logic        equal_flag;
    logic        greater_a_flag;
    logic [15:0] result_q;
    logic        equal_flag_q;
    logic        greater_a_flag_q;

    int checks = 0;
    int errors = 0;

    x3q16_alu dut (
        .clk              (clk),
        .reset            (reset),
        .a                (a),
        .b                (b),
        .mode             (mode),
        .result           (result),
        .equal_flag       (equal_flag),
        .greater_a_flag   (greater_a_flag),
        .result_q         (result_q),
        .equal_flag_q     (equal_flag_q),
        .greater_a_flag_q (greater_a_flag_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic vec(input string tag, input logic [15:0] va, input logic [15:0] vb,
                       input logic [2:0] vm, input logic [15:0] er, input logic ee, input logic eg);
        @(posedge clk);
        #1;
        a    = va;
        b    = vb;
        mode = vm;
        @(negedge clk);
        check({tag, " result"}, result, er);
        check({tag, " eq"}, {15'd0, equal_flag}, {15'd0, ee});
        check({tag, " gt"}, {15'd0, greater_a_flag}, {15'd0, eg});
    endtask

    initial begin
        reset = 1'b0;
        a     = 16'h0000;
        b     = 16'h0000;
        mode  = 3'b000;

        // Reset held two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset result_q", result_q, 16'h0000);
        check("reset eq_q", {15'd0, equal_flag_q}, 16'h0000);
        check("reset gt_q", {15'd0, greater_a_flag_q}, 16'h0000);

        @(posedge clk);
        #1 reset = 1'b1;

        vec("add wrap",     16'hFFFF, 16'h0001, 3'b000, 16'h0000, 1'b0, 1'b1);
        @(negedge clk);
        check("q add wrap result", result_q, 16'h0000);
        check("q add wrap gt", {15'd0, greater_a_flag_q}, 16'h0001);
        check("q add wrap eq", {15'd0, equal_flag_q}, 16'h0000);

        vec("add plain",    16'h1234, 16'h1111, 3'b000, 16'h2345, 1'b0, 1'b1);
        vec("sub equal",    16'h1234, 16'h1234, 3'b001, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        check("q sub equal eq", {15'd0, equal_flag_q}, 16'h0001);
        check("q sub equal gt", {15'd0, greater_a_flag_q}, 16'h0000);

        vec("sub borrow",   16'h0000, 16'h0001, 3'b001, 16'hFFFF, 1'b0, 1'b0);
        vec("sub plain",    16'h5000, 16'h0123, 3'b001, 16'h4EDD, 1'b0, 1'b1);
        vec("and",          16'hF0F0, 16'h0FF0, 3'b010, 16'h00F0, 1'b0, 1'b1);
        vec("or",           16'hF0F0, 16'h0FF0, 3'b011, 16'hFFF0, 1'b0, 1'b1);
        vec("xor",          16'hF0F0, 16'h0FF0, 3'b100, 16'hFF00, 1'b0, 1'b1);
        vec("shl 15",       16'h0001, 16'h000F, 3'b101, 16'h8000, 1'b0, 1'b0);
        vec("shl 15 ones",  16'hFFFF, 16'h000F, 3'b101, 16'h8000, 1'b0, 1'b1);
        vec("shl 0",        16'hA5C3, 16'h0000, 3'b101, 16'hA5C3, 1'b0, 1'b1);
        vec("shl hi ign",   16'h0003, 16'hFFF2, 3'b101, 16'h000C, 1'b0, 1'b0);
        vec("shr low nib",  16'h8000, 16'h0013, 3'b110, 16'h1000, 1'b0, 1'b1);
        vec("shr 15 ones",  16'hFFFF, 16'h000F, 3'b110, 16'h0001, 1'b0, 1'b1);
        vec("shr 0",        16'h5A3C, 16'h0010, 3'b110, 16'h5A3C, 1'b0, 1'b1);
        vec("not",          16'h00FF, 16'h1234, 3'b111, 16'hFF00, 1'b0, 1'b0);
        vec("ucmp gt",      16'h8000, 16'h7FFF, 3'b010, 16'h0000, 1'b0, 1'b1);
        vec("ucmp lt",      16'h7FFF, 16'h8000, 3'b110, 16'h7FFF, 1'b0, 1'b0);
        vec("ucmp eq not",  16'hBEEF, 16'hBEEF, 3'b111, 16'h4110, 1'b1, 1'b0);

        // Registered path carries a distinctive value, then reset mid-stream
        vec("q seed",       16'h1234, 16'h1111, 3'b000, 16'h2345, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("q loaded result", result_q, 16'h2345);
        check("q loaded gt", {15'd0, greater_a_flag_q}, 16'h0001);
        reset = 1'b0;
        #1;
        check("q holds until edge", result_q, 16'h2345);
        check("comb during reset", result, 16'h2345);
        check("comb gt during reset", {15'd0, greater_a_flag}, 16'h0001);
        @(negedge clk);
        check("q mid reset result", result_q, 16'h2345);
        @(negedge clk);
        check("q cleared result", result_q, 16'h0000);
        check("q cleared gt", {15'd0, greater_a_flag_q}, 16'h0000);
        check("q cleared eq", {15'd0, equal_flag_q}, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
